// File: rtl/note_key_conditioner.sv
// Seven-key front end: sync, debounce and classify raw active-low keys into note levels, strobes and a last-note code.
// Optional NOTE_LATCH_EN: each accepted press toggles the note level and release strobes are suppressed.
module note_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] key_n,
  output logic       c_note,
  output logic       d_note,
  output logic       e_note,
  output logic       f_note,
  output logic       g_note,
  output logic       a_note,
  output logic       b_note,
  output logic [6:0] press_pulse,
  output logic [6:0] release_pulse,
  output logic [2:0] last_note,
  output logic       note_valid,
  output logic [2:0] held_count
);

  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, REL_PEND} key_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [6:0]       sync1_q, sync2_q, pressed_s;
  key_state_e       state_q [7];
  key_state_e       state_d [7];
  logic [CNT_W-1:0] cnt_q   [7];
  logic [CNT_W-1:0] cnt_d   [7];
  logic [6:0]       press_ev, rel_ev, rise, fall;
  logic [6:0]       level_q, level_d;
  logic [6:0]       press_q, release_q, release_d;
  logic [2:0]       last_q, last_d, held_q, held_d;
  logic             valid_q;
  logic [7:0]       fall_ext;

  function automatic logic [2:0] top_idx(input logic [6:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] popcnt(input logic [6:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r = r + {2'b00, v[i]};
    return r;
  endfunction

  assign pressed_s = ~sync2_q;

  always_comb begin
    press_ev = '0;
    rel_ev   = '0;
    for (int i = 0; i < 7; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        RELEASED: begin
          if (pressed_s[i]) begin
            state_d[i] = PRESS_PEND;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        PRESS_PEND: begin
          if (!pressed_s[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]  = PRESSED;
            cnt_d[i]    = '0;
            press_ev[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!pressed_s[i]) begin
            state_d[i] = REL_PEND;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        REL_PEND: begin
          if (pressed_s[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
            rel_ev[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    level_d   = '0;
    release_d = '0;
`ifdef NOTE_LATCH_EN
    level_d = level_q ^ press_ev;
`else
    for (int i = 0; i < 7; i++)
      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == REL_PEND);
    release_d = rel_ev;
`endif
  end

  // A falling level of the current last note hands over to the highest key still held.
  always_comb begin
    rise     = level_d & ~level_q;
    fall     = level_q & ~level_d;
    fall_ext = {1'b0, fall};
    held_d   = popcnt(level_d);
    last_d   = last_q;
    if (|rise)
      last_d = top_idx(rise);
    else if (fall_ext[last_q] && (|level_d))
      last_d = top_idx(level_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      last_q    <= '0;
      held_q    <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_ev;
      release_q <= release_d;
      last_q    <= last_d;
      held_q    <= held_d;
      valid_q   <= |level_d;
      for (int i = 0; i < 7; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign c_note        = level_q[0];
  assign d_note        = level_q[1];
  assign e_note        = level_q[2];
  assign f_note        = level_q[3];
  assign g_note        = level_q[4];
  assign a_note        = level_q[5];
  assign b_note        = level_q[6];
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign last_note     = last_q;
  assign note_valid    = valid_q;
  assign held_count    = held_q;

endmodule
